// File: rtl/psg_bus_initiator_if.sv
// Request/response handshake plus cartridge I/O bus between the PSG
// initiator and its environment (sequencer/test host on one side, slot on the other).
interface psg_bus_initiator_if;
    // Request / response handshake
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_WRITE;
    logic [3:0] REQ_REG;
    logic [7:0] REQ_DATA;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       RSP_ERR;

    // Cartridge I/O bus
    logic [7:0] BUS_ADDR;
    logic       BUS_IORQ_n;
    logic       BUS_WR_n;
    logic       BUS_RD_n;
    logic [7:0] BUS_DOUT;
    logic [7:0] BUS_DIN;
    logic       BUS_WAIT_n;

    // The initiator drives the bus and answers requests
    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_REG, REQ_DATA, BUS_DIN, BUS_WAIT_n,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        output BUS_ADDR, BUS_IORQ_n, BUS_WR_n, BUS_RD_n, BUS_DOUT
    );

    // Host plus cartridge side
    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_REG, REQ_DATA, BUS_DIN, BUS_WAIT_n,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        input  BUS_ADDR, BUS_IORQ_n, BUS_WR_n, BUS_RD_n, BUS_DOUT
    );
endinterface

// File: rtl/psg_bus_initiator.sv
// PSG register access initiator: each request becomes an address-latch
// write to IO_BASE_ADDR+0 followed by a data write (+1) or data read (+2).
// Strobes are stretched by WAIT_n and aborted after WAIT_TIMEOUT wait cycles.
// Every output comes straight from a register, computed from the next state.
module psg_bus_initiator #(
    parameter logic [7:0] IO_BASE_ADDR  = 8'hA0,
    parameter int         STROBE_CYCLES = 4,
    parameter int         GAP_CYCLES    = 1,
    parameter int         WAIT_TIMEOUT  = 255
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    psg_bus_initiator_if.master    bus
);

    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  STROBE_LOAD = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LOAD    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(WAIT_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP1, D_SETUP, D_STROBE, D_HOLD, GAP2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              write_reg, write_next;
    logic [7:0]        data_reg, data_next;

    logic              ready_reg, ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [7:0]        rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [7:0]        addr_reg, addr_next;
    logic [7:0]        dout_reg, dout_next;
    logic              iorq_n_reg, iorq_n_next;
    logic              wr_n_reg, wr_n_next;
    logic              rd_n_reg, rd_n_next;

    // Data-phase address/data depend only on the captured direction
    logic [7:0] d_addr;
    logic [7:0] d_dout;
    assign d_addr = write_reg ? (IO_BASE_ADDR | 8'h01) : (IO_BASE_ADDR | 8'h02);
    assign d_dout = write_reg ? data_reg : 8'h00;

    // State, counters and registered outputs; reset drops strobes immediately
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            wait_cnt_reg  <= '0;
            write_reg     <= 1'b0;
            data_reg      <= 8'h00;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'h00;
            rsp_err_reg   <= 1'b0;
            addr_reg      <= 8'h00;
            dout_reg      <= 8'h00;
            iorq_n_reg    <= 1'b1;
            wr_n_reg      <= 1'b1;
            rd_n_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            write_reg     <= write_next;
            data_reg      <= data_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            addr_reg      <= addr_next;
            dout_reg      <= dout_next;
            iorq_n_reg    <= iorq_n_next;
            wr_n_reg      <= wr_n_next;
            rd_n_reg      <= rd_n_next;
        end
    end

    // Next-state sequencing, then output values decoded from the next state
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        write_next     = write_reg;
        data_next      = data_reg;
        addr_next      = addr_reg;
        dout_next      = dout_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = 8'h00;
        rsp_err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.REQ_VALID && ready_reg) begin
                    write_next = bus.REQ_WRITE;
                    data_next  = bus.REQ_DATA;
                    addr_next  = IO_BASE_ADDR;
                    dout_next  = {4'h0, bus.REQ_REG};
                    state_next = A_SETUP;
                end
            end
            A_SETUP: begin
                state_next    = A_STROBE;
                cnt_next      = STROBE_LOAD;
                wait_cnt_next = '0;
            end
            A_STROBE, D_STROBE: begin
                if (bus.BUS_WAIT_n) begin
                    if (cnt_reg == CNT_ONE) begin
                        if (state_reg == A_STROBE) begin
                            state_next = A_HOLD;
                        end else begin
                            // Last strobe cycle: read data is taken here
                            state_next     = D_HOLD;
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = write_reg ? 8'h00 : bus.BUS_DIN;
                        end
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Cartridge held WAIT too long: abort straight to the response
                    state_next     = D_HOLD;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                end
            end
            A_HOLD: begin
                if (GAP_CYCLES == 0) begin
                    state_next = D_SETUP;
                    addr_next  = d_addr;
                    dout_next  = d_dout;
                end else begin
                    state_next = GAP1;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP1: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = D_SETUP;
                    addr_next  = d_addr;
                    dout_next  = d_dout;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            D_SETUP: begin
                state_next    = D_STROBE;
                cnt_next      = STROBE_LOAD;
                wait_cnt_next = '0;
            end
            D_HOLD: begin
                if (GAP_CYCLES == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next = GAP2;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP2: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Strobes only in the strobe states; WR and RD are mutually exclusive
        ready_next  = (state_next == IDLE);
        iorq_n_next = !((state_next == A_STROBE) || (state_next == D_STROBE));
        wr_n_next   = !((state_next == A_STROBE) || ((state_next == D_STROBE) && write_next));
        rd_n_next   = !((state_next == D_STROBE) && !write_next);
    end

    assign bus.REQ_READY  = ready_reg;
    assign bus.RSP_VALID  = rsp_valid_reg;
    assign bus.RSP_DATA   = rsp_data_reg;
    assign bus.RSP_ERR    = rsp_err_reg;
    assign bus.BUS_ADDR   = addr_reg;
    assign bus.BUS_DOUT   = dout_reg;
    assign bus.BUS_IORQ_n = iorq_n_reg;
    assign bus.BUS_WR_n   = wr_n_reg;
    assign bus.BUS_RD_n   = rd_n_reg;

endmodule

// File: tb/tb_psg_bus_initiator.sv
// Directed bench for psg_bus_initiator (STROBE=4, GAP=1, WAIT_TIMEOUT=8).
// A simple cartridge returns cart_rdata on reads of port A2.
module tb_psg_bus_initiator;

    logic CLK = 1'b0;
    logic RESET_n;
    always #5 CLK = ~CLK;

    psg_bus_initiator_if bus();

    psg_bus_initiator #(
        .IO_BASE_ADDR (8'hA0),
        .STROBE_CYCLES(4),
        .GAP_CYCLES   (1),
        .WAIT_TIMEOUT (8)
    ) dut (
        .CLK    (CLK),
        .RESET_n(RESET_n),
        .bus    (bus)
    );

    logic [7:0] cart_rdata;
    assign bus.BUS_DIN = (!bus.BUS_RD_n && !bus.BUS_IORQ_n && bus.BUS_ADDR == 8'hA2) ? cart_rdata : 8'h00;

    int checks = 0;
    int errors = 0;

    // Monitor state, cleared per transaction
    int         rsp_cnt, rsp_cyc, rsp_last, rdy_cyc;
    int         a_low, d_wr_low, d_rd_low, runs, gap_len, unstable, bad_strobe;
    logic [7:0] rsp_data_s, a_dout_s, d_dout_s, d_dout_first, prev_addr, prev_dout;
    logic       rsp_err_s, in_strobe, d_first_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_mon();
        rsp_cnt = 0; rsp_cyc = -1; rsp_last = -1; rdy_cyc = -1;
        a_low = 0; d_wr_low = 0; d_rd_low = 0; runs = 0; gap_len = 0;
        unstable = 0; bad_strobe = 0;
        rsp_data_s = 8'h00; rsp_err_s = 1'b0; a_dout_s = 8'h00; d_dout_s = 8'h00;
        d_dout_first = 8'h00; d_first_seen = 1'b0; in_strobe = 1'b0;
        prev_addr = 8'h00; prev_dout = 8'h00;
    endtask

    // Called once per cycle at the falling edge; k = cycles since acceptance
    task automatic sample(input int k);
        if (bus.RSP_VALID) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
                rsp_cyc    = k;
                rsp_data_s = bus.RSP_DATA;
                rsp_err_s  = bus.RSP_ERR;
            end
            rsp_last = k;
        end
        if (!bus.BUS_IORQ_n) begin
            if (in_strobe) begin
                if (bus.BUS_ADDR !== prev_addr || bus.BUS_DOUT !== prev_dout) unstable++;
            end else begin
                runs++;
            end
            in_strobe = 1'b1;
            prev_addr = bus.BUS_ADDR;
            prev_dout = bus.BUS_DOUT;
            if (!bus.BUS_WR_n && bus.BUS_ADDR == 8'hA0) begin a_low++; a_dout_s = bus.BUS_DOUT; end
            if (!bus.BUS_WR_n && bus.BUS_ADDR == 8'hA1) begin
                d_wr_low++;
                d_dout_s = bus.BUS_DOUT;
                if (!d_first_seen) begin d_first_seen = 1'b1; d_dout_first = bus.BUS_DOUT; end
            end
            if (!bus.BUS_RD_n && bus.BUS_ADDR == 8'hA2) d_rd_low++;
        end else begin
            in_strobe = 1'b0;
            if (runs == 1) gap_len++;
            if (!bus.BUS_WR_n || !bus.BUS_RD_n) bad_strobe++;
        end
        if (!bus.BUS_WR_n && !bus.BUS_RD_n) bad_strobe++;
        if (k > 0 && rdy_cyc < 0 && bus.REQ_READY) rdy_cyc = k;
    endtask

    // wmode: 0 = no wait, 1 = 3 wait cycles mid data strobe, 2 = WAIT_n stuck low
    task automatic do_txn(input string name, input logic wr, input logic [3:0] r,
                          input logic [7:0] d, input int wmode);
        int  k;
        bit  done;
        reset_mon();
        bus.REQ_WRITE  = wr;
        bus.REQ_REG    = r;
        bus.REQ_DATA   = d;
        bus.REQ_VALID  = 1'b1;
        bus.BUS_WAIT_n = (wmode == 2) ? 1'b0 : 1'b1;
        check_val({name, "_ready_before"}, 32'(bus.REQ_READY), 32'd1);
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_DATA  = 8'hEE;
        bus.REQ_REG   = 4'hF;
        bus.REQ_WRITE = ~wr;
        k = 0;
        done = 1'b0;
        while (!done && k < 60) begin
            @(negedge CLK);
            k++;
            sample(k);
            if (wmode == 1) bus.BUS_WAIT_n = !(d_wr_low >= 2 && d_wr_low <= 4);
            if (k > 1 && bus.REQ_READY) done = 1'b1;
        end
        bus.BUS_WAIT_n = 1'b1;
        check_val({name, "_completed"}, 32'(done), 32'd1);
        $display("txn %s wr=%0d reg=%0d rsp@%0d data=%02h err=%0d ready@%0d",
                 name, wr, r, rsp_cyc, rsp_data_s, rsp_err_s, rdy_cyc);
    endtask

    initial begin
        int acc2;
        RESET_n        = 1'b0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WRITE  = 1'b0;
        bus.REQ_REG    = 4'h0;
        bus.REQ_DATA   = 8'h00;
        bus.BUS_WAIT_n = 1'b1;
        cart_rdata     = 8'hB8;

        // Reset state
        #12;
        check_val("rst_ready",  32'(bus.REQ_READY),  32'd1);
        check_val("rst_rspv",   32'(bus.RSP_VALID),  32'd0);
        check_val("rst_rspd",   32'(bus.RSP_DATA),   32'h00);
        check_val("rst_rspe",   32'(bus.RSP_ERR),    32'd0);
        check_val("rst_addr",   32'(bus.BUS_ADDR),   32'h00);
        check_val("rst_dout",   32'(bus.BUS_DOUT),   32'h00);
        check_val("rst_strobe", 32'({bus.BUS_IORQ_n, bus.BUS_WR_n, bus.BUS_RD_n}), 32'h7);
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Register write 7 <= 38: OUT A0,07 then OUT A1,38
        do_txn("wr7", 1'b1, 4'd7, 8'h38, 0);
        check_val("wr7_rsp_cyc",  32'(rsp_cyc),    32'd13);
        check_val("wr7_rsp_cnt",  32'(rsp_cnt),    32'd1);
        check_val("wr7_rsp_err",  32'(rsp_err_s),  32'd0);
        check_val("wr7_rsp_data", 32'(rsp_data_s), 32'h00);
        check_val("wr7_a_low",    32'(a_low),      32'd4);
        check_val("wr7_a_dout",   32'(a_dout_s),   32'h07);
        check_val("wr7_d_low",    32'(d_wr_low),   32'd4);
        check_val("wr7_d_dout",   32'(d_dout_s),   32'h38);
        check_val("wr7_rd_low",   32'(d_rd_low),   32'd0);
        check_val("wr7_gap",      32'(gap_len),    32'd3);
        check_val("wr7_ready",    32'(rdy_cyc),    32'd15);
        check_val("wr7_stable",   32'(unstable + bad_strobe), 32'd0);

        // Register read 7, cartridge returns B8
        do_txn("rd7", 1'b0, 4'd7, 8'h00, 0);
        check_val("rd7_rsp_cyc",  32'(rsp_cyc),    32'd13);
        check_val("rd7_rsp_data", 32'(rsp_data_s), 32'hB8);
        check_val("rd7_rsp_err",  32'(rsp_err_s),  32'd0);
        check_val("rd7_a_low",    32'(a_low),      32'd4);
        check_val("rd7_a_dout",   32'(a_dout_s),   32'h07);
        check_val("rd7_rd_low",   32'(d_rd_low),   32'd4);
        check_val("rd7_wr_low",   32'(d_wr_low),   32'd0);
        check_val("rd7_stable",   32'(unstable + bad_strobe), 32'd0);

        // Three wait cycles in the data strobe stretch it to 7 cycles
        do_txn("wait3", 1'b1, 4'd3, 8'h5A, 1);
        check_val("wait3_d_low",   32'(d_wr_low),   32'd7);
        check_val("wait3_d_dout",  32'(d_dout_s),   32'h5A);
        check_val("wait3_a_dout",  32'(a_dout_s),   32'h03);
        check_val("wait3_rsp_cyc", 32'(rsp_cyc),    32'd16);
        check_val("wait3_rsp_err", 32'(rsp_err_s),  32'd0);
        check_val("wait3_stable",  32'(unstable + bad_strobe), 32'd0);

        // WAIT_n stuck low: abort after 8 wait cycles in the address strobe
        cart_rdata = 8'h5C;
        do_txn("tmo", 1'b0, 4'd9, 8'h00, 2);
        check_val("tmo_a_low",    32'(a_low),      32'd8);
        check_val("tmo_rd_low",   32'(d_rd_low),   32'd0);
        check_val("tmo_rsp_cyc",  32'(rsp_cyc),    32'd10);
        check_val("tmo_rsp_err",  32'(rsp_err_s),  32'd1);
        check_val("tmo_rsp_data", 32'(rsp_data_s), 32'h00);
        check_val("tmo_rsp_cnt",  32'(rsp_cnt),    32'd1);
        check_val("tmo_ready",    32'(rdy_cyc),    32'd12);

        // Back-to-back with VALID held; request fields changed after acceptance
        reset_mon();
        acc2 = -1;
        bus.REQ_WRITE = 1'b1;
        bus.REQ_REG   = 4'd1;
        bus.REQ_DATA  = 8'h11;
        bus.REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            sample(k);
            if (k == 1) bus.REQ_DATA = 8'h22;
            if (acc2 < 0 && bus.REQ_READY) acc2 = k;
            if (acc2 >= 0 && k > acc2) bus.REQ_VALID = 1'b0;
        end
        bus.REQ_VALID = 1'b0;
        check_val("b2b_acc2",     32'(acc2),         32'd15);
        check_val("b2b_rsp_cnt",  32'(rsp_cnt),      32'd2);
        check_val("b2b_rsp1",     32'(rsp_cyc),      32'd13);
        check_val("b2b_rsp2",     32'(rsp_last),     32'd28);
        check_val("b2b_dout1",    32'(d_dout_first), 32'h11);
        check_val("b2b_dout2",    32'(d_dout_s),     32'h22);
        check_val("b2b_ready_end", 32'(bus.REQ_READY), 32'd1);
        $display("txn b2b acc2@%0d rsp@%0d,%0d data=%02h,%02h", acc2, rsp_cyc, rsp_last, d_dout_first, d_dout_s);

        // Reset pulse during the address strobe
        reset_mon();
        bus.REQ_WRITE = 1'b1;
        bus.REQ_REG   = 4'd2;
        bus.REQ_DATA  = 8'h77;
        bus.REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rstmid_iorq_before", 32'(bus.BUS_IORQ_n), 32'd0);
        #2;
        RESET_n = 1'b0;
        #1;
        check_val("rstmid_strobe", 32'({bus.BUS_IORQ_n, bus.BUS_WR_n, bus.BUS_RD_n}), 32'h7);
        check_val("rstmid_ready",  32'(bus.REQ_READY), 32'd1);
        @(negedge CLK);
        RESET_n = 1'b1;
        reset_mon();
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            sample(k);
        end
        check_val("rstmid_no_rsp",  32'(rsp_cnt),      32'd0);
        check_val("rstmid_no_strb", 32'(runs),         32'd0);
        check_val("rstmid_ready_after", 32'(bus.REQ_READY), 32'd1);
        $display("txn rstmid rsp_count=%0d strobe_runs=%0d", rsp_cnt, runs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
